// File: rtl/kalman_pkg.sv
// Shared constants and FSM encoding for the Kalman step sequencer and its
// measurement buffer.
package kalman_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int VEC_WIDTH      = 3 * DATA_WIDTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_WAIT_CLR  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/meas_fifo.sv
// Synchronous measurement FIFO. A push while full is refused even when a pop
// happens on the same edge; pointers wrap naturally at the power-of-2 depth.
module meas_fifo
  import kalman_pkg::*;
#(
  parameter int WIDTH = VEC_WIDTH,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kalman_step_sequencer.sv
// Streams buffered 3-D measurements through kalman_fsm_3d, one start/done
// handshake per sample, and presents each estimate on a valid/ready port.
module kalman_step_sequencer
  import kalman_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         meas_valid,
  output logic                         meas_ready,
  input  logic signed [DATA_WIDTH-1:0] meas_x,
  input  logic signed [DATA_WIDTH-1:0] meas_y,
  input  logic signed [DATA_WIDTH-1:0] meas_z,
  output logic                         est_valid,
  input  logic                         est_ready,
  output logic signed [DATA_WIDTH-1:0] est_x,
  output logic signed [DATA_WIDTH-1:0] est_y,
  output logic signed [DATA_WIDTH-1:0] est_z,
  output logic                         kf_start,
  input  logic                         kf_done,
  output logic signed [DATA_WIDTH-1:0] kf_z_x,
  output logic signed [DATA_WIDTH-1:0] kf_z_y,
  output logic signed [DATA_WIDTH-1:0] kf_z_z,
  input  logic signed [DATA_WIDTH-1:0] kf_x_x,
  input  logic signed [DATA_WIDTH-1:0] kf_x_y,
  input  logic signed [DATA_WIDTH-1:0] kf_x_z,
  output logic [CNT_WIDTH-1:0]         step_count,
  output logic                         timeout_err,
  output logic                         busy
);

  localparam int VW = 3 * DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] PHASE_LAST = TW'(TIMEOUT_CYCLES - 1);

  seq_state_t     state;
  logic [TW-1:0]  phase_cnt;
  logic           phase_expired;
  logic [VW-1:0]  fifo_wdata;
  logic [VW-1:0]  fifo_rdata;
  logic           fifo_full;
  logic           fifo_empty;
  logic [AW:0]    fifo_count;
  logic           fifo_push;
  logic           fifo_pop;

  assign meas_ready    = !rst && !fifo_full;
  assign fifo_push     = meas_valid && meas_ready;
  assign fifo_wdata    = {meas_x, meas_y, meas_z};
  assign phase_expired = (phase_cnt == PHASE_LAST);

  // A new step only launches once the previous estimate has been taken and
  // the filter has dropped done, so estimates are never overwritten.
  assign fifo_pop = (state == ST_IDLE) && !fifo_empty && !est_valid && !kf_done;

  assign busy = (state != ST_IDLE) || (fifo_count != '0);

  meas_fifo #(
    .WIDTH (VW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      phase_cnt   <= '0;
      kf_start    <= 1'b0;
      kf_z_x      <= '0;
      kf_z_y      <= '0;
      kf_z_z      <= '0;
      est_valid   <= 1'b0;
      est_x       <= '0;
      est_y       <= '0;
      est_z       <= '0;
      step_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (est_valid && est_ready) begin
        est_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            {kf_z_x, kf_z_y, kf_z_z} <= fifo_rdata;
            kf_start  <= 1'b1;
            phase_cnt <= '0;
            state     <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (kf_done) begin
            est_x      <= kf_x_x;
            est_y      <= kf_x_y;
            est_z      <= kf_x_z;
            est_valid  <= 1'b1;
            kf_start   <= 1'b0;
            step_count <= step_count + 1'b1;
            phase_cnt  <= '0;
            state      <= ST_WAIT_CLR;
          end else if (phase_expired) begin
            // Aborted sample is dropped: no estimate and no step counted.
            timeout_err <= 1'b1;
            kf_start    <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_WAIT_CLR: begin
          if (!kf_done) begin
            state <= ST_IDLE;
          end else if (phase_expired) begin
            timeout_err <= 1'b1;
            kf_start    <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: begin
          kf_start <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
